// File: rtl/trace_sequencer_pkg.sv
// trace_sequencer_pkg: FSM state type and default widths shared with the trace ROM and cache
package trace_sequencer_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/trace_sequencer_sat_counter.sv
// sat_counter: clearable up-counter that sticks at its maximum instead of wrapping
module sat_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/trace_sequencer.sv
// trace_sequencer: replays trace ROM entries 0..TRACE_LEN-1 into the cache, one outstanding request
// at a time, and tallies hit/miss/reference statistics.
module trace_sequencer
    import trace_sequencer_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TRACE_LEN = 6,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  trace_addr,
    input  logic [DATA_W-1:0]  trace_ref,
    output logic               req_valid,
    output logic [DATA_W-1:0]  req_addr,
    input  logic               req_ready,
    input  logic               resp_valid,
    input  logic               resp_hit,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] ref_count,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);
    // Truncation only matters for TRACE_LEN=0, where WAIT is never reached.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TRACE_LEN - 1);
    state_t state;
    logic   restart, resp_take;
    assign restart   = (state == IDLE || state == DONE) && start;
    assign resp_take = state == WAIT && resp_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trace_addr <= '0;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    trace_addr <= '0;
                    busy       <= TRACE_LEN != 0;
                    done       <= TRACE_LEN == 0;
                    state      <= TRACE_LEN == 0 ? DONE : FETCH;
                end
                FETCH: begin
                    req_addr  <= trace_ref;
                    req_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: if (req_ready) begin
                    req_valid <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (resp_valid) begin
                    if (trace_addr == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        trace_addr <= trace_addr + 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    sat_counter #(.COUNT_W(COUNT_W)) u_ref  (.clk(clk), .rst(rst), .clear(restart), .inc(resp_take), .count(ref_count));
    sat_counter #(.COUNT_W(COUNT_W)) u_hit  (.clk(clk), .rst(rst), .clear(restart), .inc(resp_take && resp_hit), .count(hit_count));
    sat_counter #(.COUNT_W(COUNT_W)) u_miss (.clk(clk), .rst(rst), .clear(restart), .inc(resp_take && !resp_hit), .count(miss_count));
endmodule
